telemetry_update_scheduler: RTL

Arbitrates value updates from several producer blocks into the telemetry overlay's per-signal value array. Each producer posts (signal index, value) over a valid/ready handshake. A round-robin arbiter accepts at most one update per cycle into a shadow register bank. The shadow bank is committed to the display bank only on frame_start, so the panel's values never change mid-frame (no tearing). Output value_out feeds the value[] input of telemetry_panel directly.

---
 rtl/telemetry_update_scheduler_if.sv | 19 +
 rtl/telemetry_update_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/telemetry_update_scheduler_if.sv
// Producer-to-scheduler update bus.
//   req_valid[r]  producer r has an update pending (held with data until accepted)
//   req_idx[r]    target signal index for producer r
//   req_value[r]  value for producer r
//   req_ready[r]  one-hot-or-zero grant from the scheduler; accept = valid & ready
// Modports: master = producer side, slave = scheduler side.
interface telemetry_update_scheduler_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDX_BITS    = 3,
  parameter int unsigned VALUE_WIDTH = 9
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][IDX_BITS-1:0]    req_idx;
  logic [NUM_REQ-1:0][VALUE_WIDTH-1:0] req_value;
  logic [NUM_REQ-1:0]                  req_ready;

  modport master (output req_valid, output req_idx, output req_value, input req_ready);
  modport slave  (input req_valid, input req_idx, input req_value, output req_ready);
endinterface

// File: rtl/telemetry_update_scheduler.sv
// Telemetry update scheduler.
// Round-robin arbitrates (index, value) updates from NUM_REQ producers into a shadow
// bank, one accept per cycle. The shadow bank is copied into the display bank
// (value_out) only in the COMMIT cycle that follows frame_start, so the panel never
// sees a value change mid-frame.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   frame_start  single-cycle pulse at start of vertical blank
//   req          update bus (slave modport): req_valid/req_idx/req_value in, req_ready out
//   value_out    committed display values, one per signal
//   commit_pulse high for one cycle right after value_out was loaded
//   pending      shadow bank holds uncommitted writes
//   bad_index    sticky flag: an accepted request targeted an index >= NUM_SIGNALS
// Optional build macro TELEMETRY_SCHED_SATURATE_EN: clamps accepted values to
// 10**NUM_VALUE_DIGITS - 1 so the panel never has to drop high-order digits.
module telemetry_update_scheduler #(
  parameter int unsigned NUM_SIGNALS      = 7,
  parameter int unsigned VALUE_WIDTH      = 9,
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned NUM_VALUE_DIGITS = 3,
  parameter int unsigned IDX_BITS         = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   frame_start,
  telemetry_update_scheduler_if.slave            req,
  output logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] value_out,
  output logic                                   commit_pulse,
  output logic                                   pending,
  output logic                                   bad_index
);

  localparam int unsigned PtrBits = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StCommit = 1'b1;

`ifdef TELEMETRY_SCHED_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif
  localparam int unsigned              SatLimit = 10 ** NUM_VALUE_DIGITS - 1;
  localparam logic [VALUE_WIDTH-1:0]   SatValue = VALUE_WIDTH'(SatLimit);

  logic [0:0]                                state_q, state_d;
  logic [PtrBits-1:0]                        ptr_q, ptr_d;
  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]   shadow_q, shadow_d;
  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0]   value_q, value_d;
  logic [NUM_SIGNALS-1:0]                    dirty_q, dirty_d;
  logic                                      bad_q, bad_d;
  logic                                      pulse_q;

  // Round-robin arbiter: first valid requester at or after the pointer wins.
  logic [NUM_REQ-1:0] grant;
  logic [PtrBits-1:0] gnt_idx;
  logic [PtrBits-1:0] cand;
  logic               gnt_found;

  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    cand      = '0;
    gnt_found = 1'b0;
    if (state_q == StRun) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = PtrBits'((32'(ptr_q) + k) % NUM_REQ);
        if (!gnt_found && req.req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
      if (gnt_found) grant[gnt_idx] = 1'b1;
    end
  end

  assign req.req_ready = grant;

  logic [IDX_BITS-1:0]    acc_idx;
  logic [VALUE_WIDTH-1:0] acc_value;
  logic [VALUE_WIDTH-1:0] store_value;
  logic                   in_range;

  assign acc_idx   = req.req_idx[gnt_idx];
  assign acc_value = req.req_value[gnt_idx];
  assign in_range  = (32'(acc_idx) < NUM_SIGNALS);

  // Comparison is done at 64 bits so a limit wider than VALUE_WIDTH never clamps.
  always_comb begin
    store_value = acc_value;
    if (SatEn && (64'(acc_value) > 64'(SatLimit))) store_value = SatValue;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    shadow_d = shadow_q;
    value_d  = value_q;
    dirty_d  = dirty_q;
    bad_d    = bad_q;
    if (state_q == StCommit) begin
      // Only dirty entries are copied; the rest keep their displayed value.
      for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
        if (dirty_q[i]) value_d[i] = shadow_q[i];
      end
      dirty_d = '0;
      state_d = StRun;
    end else begin
      if (gnt_found) begin
        ptr_d = PtrBits'((32'(gnt_idx) + 32'd1) % NUM_REQ);
        if (in_range) begin
          for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
            if (acc_idx == IDX_BITS'(i)) begin
              shadow_d[i] = store_value;
              dirty_d[i]  = 1'b1;
            end
          end
        end else begin
          bad_d = 1'b1;
        end
      end
      // frame_start during COMMIT falls into the other branch and is dropped.
      if (frame_start) state_d = StCommit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      ptr_q    <= '0;
      shadow_q <= '0;
      value_q  <= '0;
      dirty_q  <= '0;
      bad_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      value_q  <= value_d;
      dirty_q  <= dirty_d;
      bad_q    <= bad_d;
      pulse_q  <= (state_q == StCommit);
    end
  end

  assign value_out    = value_q;
  assign commit_pulse = pulse_q;
  assign pending      = |dirty_q;
  assign bad_index    = bad_q;

endmodule
